// File: rtl/pipe_mux_pkg.sv
// pipe_mux_pkg: shared state encoding and default sizes for pipe_mux
package pipe_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

endpackage

// File: rtl/skid_buf.sv
// skid_buf: two-entry skid buffer (main + skid register) with registered ready/valid
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous discard of all entries and of any same-cycle push
//   in_valid, in_entry   upstream offer; in_ready is a registered accept indication
//   accept               a push really happens at this edge
//   out_valid, out_entry main register contents; out_ready is the downstream accept
module skid_buf
    import pipe_mux_pkg::*;
#(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_entry,
    output logic          in_ready,
    output logic          accept,
    output logic          out_valid,
    output logic [DW-1:0] out_entry,
    input  logic          out_ready
);

    state_t        state, next;
    logic          deq, load_main, load_skid, pop_skid;
    logic [DW-1:0] skid_q;

    assign deq    = out_valid && out_ready;
    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        next      = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: begin
                next      = accept ? ONE : EMPTY;
                load_main = accept;
            end
            ONE: begin
                // simultaneous push and pop replaces main in place
                next      = (accept && !deq) ? TWO : (!accept && deq) ? EMPTY : ONE;
                load_main = accept && deq;
                load_skid = accept && !deq;
            end
            TWO: begin
                next     = deq ? ONE : TWO;
                pop_skid = deq;
            end
            default: next = EMPTY;
        endcase
        if (flush) begin
            next     = EMPTY;
            pop_skid = 1'b0;
        end
    end

    // in_ready/out_valid are flops loaded from the next state so neither
    // depends combinationally on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_entry <= '0;
            skid_q    <= '0;
        end else begin
            state     <= next;
            in_ready  <= (next != TWO);
            out_valid <= (next != EMPTY);
            if (load_main)
                out_entry <= in_entry;
            else if (pop_skid)
                out_entry <= skid_q;
            if (load_skid)
                skid_q <= in_entry;
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// pipe_mux: N-way channel select feeding a two-entry skid buffer
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data, sel         packed channels and channel index, captured on acceptance
//   in_valid, in_ready   input handshake (in_ready registered)
//   flush                synchronous discard of everything buffered
//   out_data, out_valid  registered selected data and its valid flag
//   out_ready            downstream accept
//   sel_err              one-cycle pulse after accepting an out-of-range sel
module pipe_mux
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [WIDTH:0] entry, out_entry;
    logic           accept;

    // entry = {err, data}; out-of-range index yields err=1 with zero data
    function automatic logic [WIDTH:0] pick(input logic [N*WIDTH-1:0] d, input logic [SELW-1:0] s);
        pick = {1'b1, {WIDTH{1'b0}}};
        for (int k = 0; k < N; k++)
            if (int'(s) == k)
                pick = {1'b0, d[k*WIDTH +: WIDTH]};
    endfunction

    assign entry = pick(in_data, sel);

    skid_buf #(.DW(WIDTH + 1)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_entry  (entry),
        .in_ready  (in_ready),
        .accept    (accept),
        .out_valid (out_valid),
        .out_entry (out_entry),
        .out_ready (out_ready)
    );

    // error entries always present zero data, whatever the stored payload
    assign out_data = out_entry[WIDTH] ? '0 : out_entry[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_err <= 1'b0;
        else
            sel_err <= accept && entry[WIDTH];
    end

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: queue-model bench for pipe_mux at N=4 and N=3
module tb_pipe_mux;

    typedef struct {
        logic [31:0] v4;
        logic [31:0] v3;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready, flush;
    logic [127:0] d4;
    logic [1:0]   sel;
    logic         rdy4, rdy3, ov4, ov3, se4, se3;
    logic [31:0]  od4, od3;

    ent_t q[$];
    logic exp_se3;
    int   checks = 0, errors = 0, dut_deliv = 0;

    always #5 clk = ~clk;

    pipe_mux u4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(sel), .in_valid(in_valid),
        .in_ready(rdy4), .flush(flush), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .sel_err(se4)
    );

    pipe_mux #(.WIDTH(32), .N(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(d4[95:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(rdy3), .flush(flush), .out_data(od3), .out_valid(ov3),
        .out_ready(out_ready), .sel_err(se3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready4", {31'd0, rdy4}, {31'd0, q.size() < 2});
        chk("in_ready3", {31'd0, rdy3}, {31'd0, q.size() < 2});
        chk("out_valid4", {31'd0, ov4}, {31'd0, q.size() > 0});
        chk("out_valid3", {31'd0, ov3}, {31'd0, q.size() > 0});
        chk("sel_err4", {31'd0, se4}, 32'd0);
        chk("sel_err3", {31'd0, se3}, {31'd0, exp_se3});
        if (q.size() > 0) begin
            chk("out_data4", od4, q[0].v4);
            chk("out_data3", od3, q[0].v3);
        end
    endtask

    // one clock: the model is a FIFO of capacity two, updated from the inputs seen at the edge
    task automatic step();
        logic acc;
        ent_t e;
        if (ov4 && out_ready) dut_deliv++;
        @(posedge clk);
        acc     = in_valid && (q.size() < 2) && !flush;
        exp_se3 = acc && (sel == 2'd3);
        e.v4    = d4[int'(sel)*32 +: 32];
        e.v3    = (sel == 2'd3) ? 32'd0 : e.v4;
        if (flush)
            q.delete();
        else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_model();
    endtask

    task automatic offer(input logic [1:0] s, input logic [31:0] v);
        sel = s;
        d4 = {$urandom, $urandom, $urandom, $urandom};
        d4[int'(s)*32 +: 32] = v;
        in_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; sel = '0; d4 = '0;
        exp_se3 = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, ov4}, 32'd0);
        chk("rst_in_ready", {31'd0, rdy4}, 32'd1);
        chk("rst_out_data", od4, 32'd0);
        chk("rst_sel_err", {31'd0, se3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // channel 2 pass-through with one-cycle latency
        offer(2'd2, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        step();
        chk("ch2_data", od4, 32'hDEAD_BEEF);
        chk("ch2_valid", {31'd0, ov4}, 32'd1);

        // out-of-range select on N=3 instance
        offer(2'd3, 32'h1234_5678);
        step();
        chk("bad_sel_data3", od3, 32'd0);
        chk("bad_sel_err3", {31'd0, se3}, 32'd1);
        chk("bad_sel_data4", od4, 32'h1234_5678);
        in_valid = 1'b0;
        step();
        chk("bad_sel_err_clears", {31'd0, se3}, 32'd0);
        step();

        // back-pressure: A, B fill the buffer, C must wait
        out_ready = 1'b0;
        offer(2'd0, 32'hA);
        step();
        offer(2'd1, 32'hB);
        step();
        offer(2'd2, 32'hC);
        chk("full_in_ready", {31'd0, rdy4}, 32'd0);
        step();
        chk("hold_A", od4, 32'hA);
        out_ready = 1'b1;
        step();
        chk("order_B", od4, 32'hB);
        step();
        chk("order_C", od4, 32'hC);
        in_valid = 1'b0;
        step();
        step();

        // 100-entry stream, no bubbles
        dut_deliv = 0;
        for (int i = 0; i < 100; i++) begin
            offer(2'($urandom_range(0, 3)), $urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_count", dut_deliv, 32'd100);

        // random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            offer(2'($urandom_range(0, 3)), $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;

        // flush while full with a concurrent offer
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        offer(2'd1, 32'h11); step();
        offer(2'd2, 32'h22); step();
        chk("pre_flush_full", {31'd0, rdy4}, 32'd0);
        flush = 1'b1;
        offer(2'd3, 32'h33);
        step();
        chk("flush_valid", {31'd0, ov4}, 32'd0);
        chk("flush_ready", {31'd0, rdy4}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_nothing", {31'd0, ov4}, 32'd0);

        // asynchronous reset while full
        out_ready = 1'b0;
        offer(2'd0, 32'h44); step();
        offer(2'd1, 32'h55); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, ov4}, 32'd0);
        chk("async_rst_ready", {31'd0, rdy4}, 32'd1);
        chk("async_rst_data", od4, 32'd0);
        q.delete();
        exp_se3 = 1'b0;
        #1 rst_n = 1'b1;
        offer(2'd3, 32'h66);
        out_ready = 1'b1;
        step();
        chk("post_rst_data", od4, 32'h66);
        in_valid = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
